scratch_arbiter: RTL

Two-port round-robin arbiter and sequencer for the 256 x 10-bit Scratch RAM. It shares the single RAM port between requester A (MCU core: stack push/pop, LD/ST) and requester B (auxiliary master: debug/DMA). An optional clear engine sweeps the whole RAM to a fixed value. It sits between the requesters and the Scratch RAM instance: it drives the RAM's address, write-enable and data-in, and registers the RAM's data-out back to the granted reader.

---
 rtl/scratch_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/scratch_arbiter.sv
// scratch_arbiter: round-robin arbiter and sequencer for the 256 x 10-bit
// Scratch RAM. It shares the single RAM port between requester A (core) and
// requester B (debug/DMA). Optional clear engine, compiled in when the macro
// SCR_CLEAR_EN is defined, sweeps every address to CLR_VALUE.
//
// Handshake: a requester raises REQ with stable WE/ADDR/WDATA and holds them
// until it sees GNT. GNT is combinational, and the access completes at the
// next CLK edge. REQ still high after that edge counts as a new request.
// Reads return RDATA with a one-cycle RVALID pulse in the following cycle.
module scratch_arbiter #(
  parameter logic [9:0] CLR_VALUE = 10'h000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_A,
  input  logic       WE_A,
  input  logic [7:0] ADDR_A,
  input  logic [9:0] WDATA_A,
  input  logic       REQ_B,
  input  logic       WE_B,
  input  logic [7:0] ADDR_B,
  input  logic [9:0] WDATA_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic [9:0] RDATA_A,
  output logic [9:0] RDATA_B,
  output logic       RVALID_A,
  output logic       RVALID_B,
  input  logic       CLR_START,
  output logic       CLR_BUSY,
  output logic       CLR_DONE,
  output logic [7:0] SCR_ADDR,
  output logic       SCR_WE,
  output logic [9:0] SCR_DIN,
  input  logic [9:0] SCR_DOUT
);

  logic       clearing;
  logic [7:0] sweep_addr;
  logic       gnt_a, gnt_b;
  logic [7:0] scr_addr;
  logic [9:0] scr_din;
  logic       scr_we;
  logic       last_q;          // 0 = A served last, 1 = B served last
  logic [7:0] addr_q;
  logic [9:0] din_q;
  logic       rvalid_a_q, rvalid_b_q;
  logic [9:0] rdata_a_q, rdata_b_q;

`ifdef SCR_CLEAR_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       done_q;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start is ignored while a sweep is running
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CLR_START) state_d = CLEAR;
      CLEAR:   if (cnt_q == 8'hFF) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep counter and done pulse in the first cycle back in IDLE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == CLEAR) && (cnt_q == 8'hFF);
      if (state_q == CLEAR) cnt_q <= cnt_q + 8'h01;
      else                  cnt_q <= 8'h00;
    end
  end

  assign clearing   = (state_q == CLEAR);
  assign sweep_addr = cnt_q;
  assign CLR_BUSY   = clearing;
  assign CLR_DONE   = done_q;
`else
  logic unused_clr;
  assign unused_clr = &{1'b0, CLR_START};
  assign clearing   = 1'b0;
  assign sweep_addr = 8'h00;
  assign CLR_BUSY   = 1'b0;
  assign CLR_DONE   = 1'b0;
`endif

  // Arbitration and RAM port mux; reset forces every grant low at once
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    scr_addr = addr_q;
    scr_din  = din_q;
    scr_we   = 1'b0;
    if (!RST && !clearing) begin
      if (REQ_A && (!REQ_B || last_q)) gnt_a = 1'b1;
      else if (REQ_B)                  gnt_b = 1'b1;
    end
    if (clearing) begin
      scr_addr = sweep_addr;
      scr_din  = CLR_VALUE;
      scr_we   = 1'b1;
    end else if (gnt_a) begin
      scr_addr = ADDR_A;
      scr_din  = WDATA_A;
      scr_we   = WE_A;
    end else if (gnt_b) begin
      scr_addr = ADDR_B;
      scr_din  = WDATA_B;
      scr_we   = WE_B;
    end
  end

  // Round-robin pointer, held RAM address/data, per-port read return
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q     <= 1'b1;
      addr_q     <= 8'h00;
      din_q      <= 10'h000;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= 10'h000;
      rdata_b_q  <= 10'h000;
    end else begin
      addr_q     <= scr_addr;
      din_q      <= scr_din;
      if (gnt_a)      last_q <= 1'b0;
      else if (gnt_b) last_q <= 1'b1;
      rvalid_a_q <= gnt_a && !WE_A;
      rvalid_b_q <= gnt_b && !WE_B;
      if (gnt_a && !WE_A) rdata_a_q <= SCR_DOUT;
      if (gnt_b && !WE_B) rdata_b_q <= SCR_DOUT;
    end
  end

  assign GNT_A    = gnt_a;
  assign GNT_B    = gnt_b;
  assign SCR_ADDR = scr_addr;
  assign SCR_DIN  = scr_din;
  assign SCR_WE   = scr_we;
  assign RDATA_A  = rdata_a_q;
  assign RDATA_B  = rdata_b_q;
  assign RVALID_A = rvalid_a_q;
  assign RVALID_B = rvalid_b_q;

endmodule
